// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_arbiter
// Purpose  : Shares one single-port, byte-enabled SRAM wrapper with 1-cycle
//            read latency among NUM_PORTS req/gnt/rvalid masters. One request
//            is granted per cycle. Each response is routed back to the port
//            that was granted, one cycle after the grant. Bounded bus locking
//            supports atomic read-modify-write sequences.
//
// Ports    : clk, rst_i                  clock, synchronous active-high reset
//            req_i/lock_i/we_i           per-port request, lock, write enable
//            addr_i/be_i/wdata_i         per-port packed address/BE/data
//            gnt_o                       one-hot grant (same cycle)
//            rvalid_o/rdata_o/err_o      one-hot response, shared data, error
//            ram_en_o/ram_we_o/ram_addr_o/ram_be_o/ram_wdata_o  SRAM control
//            ram_rdata_i                 SRAM read data (1 cycle after enable)
//
// Config   : SP_RAM_ARB_RR_EN  defined   -> round-robin arbitration
//                              undefined -> fixed priority, lowest index wins
//
// Revision : 1.0  initial release
// ============================================================================
module sp_ram_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 8
) (
    input  logic                              clk,
    input  logic                              rst_i,
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [NUM_PORTS-1:0]              lock_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              err_o,
    output logic                              ram_en_o,
    output logic                              ram_we_o,
    output logic [ADDR_WIDTH-1:0]             ram_addr_o,
    output logic [DATA_WIDTH/8-1:0]           ram_be_o,
    output logic [DATA_WIDTH-1:0]             ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]             ram_rdata_i
);

    localparam int                  c_be_w        = DATA_WIDTH / 8;
    localparam int                  c_id_w        = $clog2(NUM_PORTS);
    localparam int                  c_cnt_w       = $clog2(LOCK_MAX + 1);
    localparam bit                  c_range_chk   = (RAM_SIZE < (2 ** ADDR_WIDTH));
    localparam bit                  c_single_lock = (LOCK_MAX == 1);
    localparam logic [ADDR_WIDTH:0] c_ram_size    = (ADDR_WIDTH + 1)'(RAM_SIZE);
    localparam logic [c_cnt_w-1:0]  c_lock_max    = c_cnt_w'(LOCK_MAX);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e              r_state, w_state_nxt;
    logic [c_id_w-1:0]        r_owner, w_owner_nxt;
    logic [c_cnt_w-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                     r_demote_vld, w_demote_vld_nxt;
    logic [c_id_w-1:0]        r_demote_id, w_demote_id_nxt;

    logic                     r_rsp_vld;
    logic [c_id_w-1:0]        r_rsp_id;
    logic                     r_rsp_err;

    logic                     w_owner_hold;
    logic [NUM_PORTS-1:0]     w_demote_oh;
    logic [NUM_PORTS-1:0]     w_mask;
    logic [c_id_w-1:0]        w_start;
    logic                     w_gnt_any;
    logic [c_id_w-1:0]        w_sel;
    logic [ADDR_WIDTH-1:0]    w_addr_sel;
    logic [c_be_w-1:0]        w_be_sel;
    logic [DATA_WIDTH-1:0]    w_wdata_sel;
    logic                     w_oor;
    logic                     w_ram_en;

    // The lock only holds while its owner keeps requesting. Once the owner
    // drops req the lock is released combinationally, so the other ports are
    // arbitrated normally in that same cycle instead of losing a cycle.
    assign w_owner_hold = (r_state == S_LOCKED) && req_i[r_owner];

    // A port that was force-released is skipped unless it is the only requester.
    assign w_demote_oh = r_demote_vld ? (NUM_PORTS'(1) << r_demote_id) : '0;
    assign w_mask      = ((req_i & ~w_demote_oh) != '0) ? (req_i & ~w_demote_oh) : req_i;

`ifdef SP_RAM_ARB_RR_EN
    localparam logic [c_id_w-1:0] c_last_port = c_id_w'(NUM_PORTS - 1);
    logic [c_id_w-1:0] r_rr_ptr;

    assign w_start = r_rr_ptr;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_any) begin
            r_rr_ptr <= (w_sel == c_last_port) ? '0 : w_sel + 1'b1;
        end
    end
`else
    assign w_start = '0;
`endif

    // Priority search starting at w_start, wrapping modulo NUM_PORTS.
    always_comb begin : p_arb
        int w_idx;
        w_gnt_any = 1'b0;
        w_sel     = '0;
        w_idx     = 0;
        if (w_owner_hold) begin
            w_gnt_any = 1'b1;
            w_sel     = r_owner;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_idx = int'(w_start) + i;
                if (w_idx >= NUM_PORTS) begin
                    w_idx = w_idx - NUM_PORTS;
                end
                if (!w_gnt_any && w_mask[w_idx]) begin
                    w_gnt_any = 1'b1;
                    w_sel     = c_id_w'(w_idx);
                end
            end
        end
    end

    // With no grant w_sel is 0, so the RAM bus idles on port-0 values.
    assign w_addr_sel  = addr_i[int'(w_sel) * ADDR_WIDTH +: ADDR_WIDTH];
    assign w_be_sel    = be_i[int'(w_sel) * c_be_w +: c_be_w];
    assign w_wdata_sel = wdata_i[int'(w_sel) * DATA_WIDTH +: DATA_WIDTH];
    assign w_oor       = c_range_chk && ({1'b0, w_addr_sel} >= c_ram_size);
    assign w_ram_en    = w_gnt_any && !w_oor && !rst_i;

    assign gnt_o       = (w_gnt_any && !rst_i) ? (NUM_PORTS'(1) << w_sel) : '0;
    assign ram_en_o    = w_ram_en;
    assign ram_we_o    = w_ram_en && we_i[w_sel];
    assign ram_addr_o  = w_addr_sel;
    assign ram_be_o    = w_be_sel;
    assign ram_wdata_o = w_wdata_sel;

    // The response outputs are also gated by rst_i, so a response that was in
    // flight when reset arrived is never shown.
    assign rvalid_o = (r_rsp_vld && !rst_i) ? (NUM_PORTS'(1) << r_rsp_id) : '0;
    assign err_o    = r_rsp_vld && r_rsp_err && !rst_i;
    assign rdata_o  = (r_rsp_vld && !r_rsp_err && !rst_i) ? ram_rdata_i : '0;

    // Lock FSM next state. The counter saturates at LOCK_MAX and is cleared
    // on release, so it never wraps.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_cnt_nxt        = r_cnt;
        w_demote_vld_nxt = r_demote_vld;
        w_demote_id_nxt  = r_demote_id;
        w_cnt_inc        = r_cnt + 1'b1;

        if (w_gnt_any) begin
            w_demote_vld_nxt = 1'b0;
            if (w_owner_hold) begin
                if (w_cnt_inc == c_lock_max) begin
                    w_state_nxt      = S_IDLE;
                    w_cnt_nxt        = '0;
                    w_demote_vld_nxt = 1'b1;
                    w_demote_id_nxt  = r_owner;
                end else if (!lock_i[r_owner]) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end else begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                if (lock_i[w_sel]) begin
                    if (c_single_lock) begin
                        // The first locked grant already reaches LOCK_MAX.
                        w_demote_vld_nxt = 1'b1;
                        w_demote_id_nxt  = w_sel;
                    end else begin
                        w_state_nxt = S_LOCKED;
                        w_owner_nxt = w_sel;
                        w_cnt_nxt   = c_cnt_w'(1);
                    end
                end
            end
        end else if (r_state == S_LOCKED) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_demote_vld <= 1'b0;
            r_demote_id  <= '0;
            r_rsp_vld    <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            r_demote_vld <= w_demote_vld_nxt;
            r_demote_id  <= w_demote_id_nxt;
            r_rsp_vld    <= w_gnt_any;
            r_rsp_id     <= w_sel;
            r_rsp_err    <= w_gnt_any && w_oor;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_arbiter
// Purpose  : Self-checking bench for sp_ram_arbiter (3 ports, 16 KiB RAM in a
//            15-bit address space, LOCK_MAX=8). Includes a behavioural SRAM
//            wrapper and a reference model of arbitration, locking and memory.
//            Follows SP_RAM_ARB_RR_EN the same way the design does.
// Revision : 1.0  initial release
// ============================================================================
module tb_sp_ram_arbiter;

    localparam int NP = 3;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int RS = 16384;
    localparam int LM = 8;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NP-1:0]        req_i, lock_i, we_i;
    logic [NP*AW-1:0]     addr_i;
    logic [NP*DW/8-1:0]   be_i;
    logic [NP*DW-1:0]     wdata_i;
    logic [NP-1:0]        gnt_o, rvalid_o;
    logic [DW-1:0]        rdata_o;
    logic                 err_o, ram_en_o, ram_we_o;
    logic [AW-1:0]        ram_addr_o;
    logic [DW/8-1:0]      ram_be_o;
    logic [DW-1:0]        ram_wdata_o;
    logic [DW-1:0]        ram_rdata_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    int          m_locked, m_owner, m_cnt, m_ptr, m_demote;
    bit          p_vld, p_err, p_read;
    int          p_port;
    logic [31:0] p_data;
    logic [7:0]  m_mem [RS];

    // behavioural SRAM wrapper: never-written bytes read a fixed seed pattern
    logic [7:0]  ram_b  [RS];
    bit          ram_wr [RS];

    sp_ram_arbiter #(
        .NUM_PORTS (NP),
        .RAM_SIZE  (RS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LOCK_MAX  (LM)
    ) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .lock_i     (lock_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_be_o   (ram_be_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed_byte(int a);
        return 8'((a * 37) ^ (a >> 6) ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (ram_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we_o && ram_be_o[b]) begin
                    ram_b[int'({ram_addr_o[13:2], 2'b00}) + b]  <= ram_wdata_o[8*b +: 8];
                    ram_wr[int'({ram_addr_o[13:2], 2'b00}) + b] <= 1'b1;
                end
                ram_rdata_i[8*b +: 8] <= ram_wr[int'({ram_addr_o[13:2], 2'b00}) + b] ?
                                         ram_b[int'({ram_addr_o[13:2], 2'b00}) + b] :
                                         seed_byte(int'({ram_addr_o[13:2], 2'b00}) + b);
            end
        end
    end

    function automatic logic [31:0] m_word(int a);
        int base;
        base = a & ~3;
        return {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_i = '0; lock_i = '0; we_i = '0; addr_i = '0; be_i = '0; wdata_i = '0;
    endtask

    task automatic set_port(int p, bit rq, bit lk, bit w, logic [AW-1:0] a, logic [3:0] be, logic [31:0] d);
        req_i[p] = rq;
        lock_i[p] = lk;
        we_i[p] = w;
        addr_i[p*AW +: AW] = a;
        be_i[p*4 +: 4] = be;
        wdata_i[p*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_demote = -1; p_vld = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        model_reset();
    endtask

    // Winner per the rules: a requesting lock owner always wins; otherwise
    // scan from the priority start, skipping a demoted port on the first pass.
    function automatic int model_pick();
        int start, cand;
        if (m_locked != 0 && req_i[m_owner]) return m_owner;
`ifdef SP_RAM_ARB_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NP; i++) begin
                cand = (start + i) % NP;
                if (req_i[cand] && (pass == 1 || cand != m_demote)) return cand;
            end
        end
        return -1;
    endfunction

    task automatic model_commit(int g, bit oor);
        int a;
        if (m_locked != 0 && !req_i[m_owner]) m_locked = 0;
        if (g < 0) begin
            p_vld = 0;
            return;
        end
        m_demote = -1;
        if (m_locked != 0) begin
            m_cnt++;
            if (m_cnt == LM) begin
                m_locked = 0;
                m_demote = g;
            end else if (!lock_i[g]) begin
                m_locked = 0;
            end
        end else if (lock_i[g]) begin
            m_locked = 1; m_owner = g; m_cnt = 1;
        end
        m_ptr  = (g + 1) % NP;
        a      = int'(addr_i[g*AW +: AW]);
        p_vld  = 1;
        p_port = g;
        p_err  = oor;
        p_read = !we_i[g];
        if (!oor) begin
            if (p_read) begin
                p_data = m_word(a);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be_i[g*4 + b]) m_mem[(a & ~3) + b] = wdata_i[g*DW + 8*b +: 8];
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        set_port(0, 1, 0, 1, 15'h0004, 4'hF, 32'h12345678);
        set_port(1, 1, 1, 0, 15'h0008, 4'hF, 32'h0);
        @(negedge clk);
        n_cmp++; if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL rst_gnt: got %b want 000", gnt_o); end
        n_cmp++; if (ram_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got %b want 0", ram_en_o); end
        n_cmp++; if (ram_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", ram_we_o); end
        n_cmp++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid: got %b want 000", rvalid_o); end
        n_cmp++; if (err_o !== 1'b0 || rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rsp: got err=%b rdata=%h want 0/0", err_o, rdata_o); end
        next_cycle();
    endtask

    task automatic test_single_read();
        do_reset();
        set_port(0, 1, 0, 0, 15'h0010, 4'hF, 32'h0);
        @(negedge clk);
        n_cmp++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL sr_gnt: got %b want 001", gnt_o); end
        n_cmp++; if (ram_en_o !== 1'b1 || ram_we_o !== 1'b0) begin n_fail++; $display("FAIL sr_en: got en=%b we=%b want 1/0", ram_en_o, ram_we_o); end
        n_cmp++; if (ram_addr_o !== 15'h0010) begin n_fail++; $display("FAIL sr_addr: got %h want 0010", ram_addr_o); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (rvalid_o !== 3'b001) begin n_fail++; $display("FAIL sr_rvalid: got %b want 001", rvalid_o); end
        n_cmp++; if (rdata_o !== m_word(16) || err_o !== 1'b0) begin n_fail++; $display("FAIL sr_rdata: got %h err=%b want %h err=0", rdata_o, err_o, m_word(16)); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [NP-1:0] exp_g [4];
`ifdef SP_RAM_ARB_RR_EN
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b001; exp_g[3] = 3'b010;
`else
        exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
`endif
        do_reset();
        set_port(0, 1, 0, 0, 15'h0020, 4'hF, 32'h0);
        set_port(1, 1, 0, 0, 15'h0024, 4'hF, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (gnt_o !== exp_g[c]) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %b want %b", c, gnt_o, exp_g[c]); end
            if (c > 0) begin
                n_cmp++; if (rvalid_o !== exp_g[c-1]) begin n_fail++; $display("FAIL cont_rvalid[%0d]: got %b want %b", c, rvalid_o, exp_g[c-1]); end
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (rvalid_o !== exp_g[3]) begin n_fail++; $display("FAIL cont_rvalid_last: got %b want %b", rvalid_o, exp_g[3]); end
        next_cycle();
    endtask

    task automatic test_lock();
        logic [NP-1:0] exp_g;
        logic [NP-1:0] c9_a;
`ifdef SP_RAM_ARB_RR_EN
        c9_a = 3'b010;
`else
        c9_a = 3'b001;
`endif
        // port 1 locks, port 0 queues behind it
        do_reset();
        set_port(1, 1, 1, 0, 15'h0030, 4'hF, 32'h0);
        for (int c = 0; c < 10; c++) begin
            if (c == 1) set_port(0, 1, 0, 0, 15'h0034, 4'hF, 32'h0);
            exp_g = (c < 8) ? 3'b010 : ((c == 8) ? 3'b001 : c9_a);
            @(negedge clk);
            n_cmp++; if (gnt_o !== exp_g) begin n_fail++; $display("FAIL lockA_gnt[%0d]: got %b want %b", c, gnt_o, exp_g); end
            next_cycle();
        end
        // port 0 locks: after the forced release it must yield once to port 1
        do_reset();
        set_port(0, 1, 1, 0, 15'h0040, 4'hF, 32'h0);
        set_port(1, 1, 0, 0, 15'h0044, 4'hF, 32'h0);
        for (int c = 0; c < 10; c++) begin
            exp_g = (c == 8) ? 3'b010 : 3'b001;
            @(negedge clk);
            n_cmp++; if (gnt_o !== exp_g) begin n_fail++; $display("FAIL lockB_gnt[%0d]: got %b want %b", c, gnt_o, exp_g); end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_byte_write();
        logic [31:0] old_w;
        do_reset();
        old_w = m_word(8);
        set_port(0, 1, 0, 1, 15'h0008, 4'b0100, 32'hAABBCCDD);
        @(negedge clk);
        n_cmp++; if (ram_we_o !== 1'b1 || ram_en_o !== 1'b1) begin n_fail++; $display("FAIL bw_we: got we=%b en=%b want 1/1", ram_we_o, ram_en_o); end
        n_cmp++; if (ram_be_o !== 4'b0100) begin n_fail++; $display("FAIL bw_be: got %b want 0100", ram_be_o); end
        n_cmp++; if (ram_wdata_o !== 32'hAABBCCDD) begin n_fail++; $display("FAIL bw_wdata: got %h want aabbccdd", ram_wdata_o); end
        m_mem[10] = 8'hBB;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (rvalid_o !== 3'b001) begin n_fail++; $display("FAIL bw_rvalid: got %b want 001", rvalid_o); end
        next_cycle();
        set_port(0, 1, 0, 0, 15'h0008, 4'hF, 32'h0);
        @(negedge clk);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (rdata_o !== {old_w[31:24], 8'hBB, old_w[15:0]}) begin n_fail++; $display("FAIL bw_readback: got %h want %h", rdata_o, {old_w[31:24], 8'hBB, old_w[15:0]}); end
        next_cycle();
    endtask

    task automatic test_out_of_range();
        do_reset();
        set_port(0, 1, 0, 0, 15'h4000, 4'hF, 32'h0);
        @(negedge clk);
        n_cmp++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL oor_gnt: got %b want 001", gnt_o); end
        n_cmp++; if (ram_en_o !== 1'b0) begin n_fail++; $display("FAIL oor_en: got %b want 0", ram_en_o); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (rvalid_o !== 3'b001 || err_o !== 1'b1) begin n_fail++; $display("FAIL oor_rsp: got rvalid=%b err=%b want 001/1", rvalid_o, err_o); end
        n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %h want 0", rdata_o); end
        next_cycle();
    endtask

    task automatic test_reset_midop();
        do_reset();
        set_port(0, 1, 1, 0, 15'h0050, 4'hF, 32'h0);
        @(negedge clk);
        n_cmp++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL mid_gnt: got %b want 001", gnt_o); end
        next_cycle();
        rst_i = 1'b1;
        set_port(1, 1, 0, 0, 15'h0054, 4'hF, 32'h0);
        @(negedge clk);
        n_cmp++; if (rvalid_o !== 3'b000 || gnt_o !== 3'b000) begin n_fail++; $display("FAIL mid_rst_out: got rvalid=%b gnt=%b want 000/000", rvalid_o, gnt_o); end
        n_cmp++; if (ram_en_o !== 1'b0 || ram_we_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_bus: got en=%b we=%b err=%b rdata=%h want zeros", ram_en_o, ram_we_o, err_o, rdata_o); end
        next_cycle();
        rst_i = 1'b0;
        model_reset();
        lock_i = '0;
        @(negedge clk);
        n_cmp++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL mid_drop: got %b want 000", rvalid_o); end
        n_cmp++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL mid_first_arb: got %b want 001", gnt_o); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        int            hold [NP];
        int            g;
        bit            oor, rq, lk;
        logic [AW-1:0] a;
        logic [NP-1:0] exp_v;
        do_reset();
        for (int p = 0; p < NP; p++) hold[p] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (hold[p] == 0 && $urandom_range(0, 15) == 0) hold[p] = $urandom_range(4, 12);
                if (hold[p] > 0) begin
                    rq = 1; lk = 1; hold[p]--;
                end else begin
                    rq = ($urandom_range(0, 9) < 6);
                    lk = ($urandom_range(0, 3) == 0);
                end
                a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(RS, 2**AW - 1)) : AW'($urandom_range(0, RS - 1));
                set_port(p, rq, lk, ($urandom_range(0, 2) == 0), a, 4'($urandom), $urandom);
            end
            @(negedge clk);
            exp_v = p_vld ? NP'(1 << p_port) : '0;
            n_cmp++; if (rvalid_o !== exp_v) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, rvalid_o, exp_v); end
            n_cmp++; if (err_o !== (p_vld && p_err)) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", c, err_o, p_vld && p_err); end
            if (p_vld && (p_err || p_read)) begin
                n_cmp++; if (rdata_o !== (p_err ? 32'h0 : p_data)) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata_o, p_err ? 32'h0 : p_data); end
            end
            g     = model_pick();
            oor   = (g >= 0) && (int'(addr_i[g*AW +: AW]) >= RS);
            exp_v = (g >= 0) ? NP'(1 << g) : '0;
            n_cmp++; if (gnt_o !== exp_v) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, gnt_o, exp_v); end
            n_cmp++; if (ram_en_o !== (g >= 0 && !oor)) begin n_fail++; $display("FAIL rnd_en[%0d]: got %b want %b", c, ram_en_o, g >= 0 && !oor); end
            if (g >= 0) begin
                n_cmp++; if (ram_addr_o !== addr_i[g*AW +: AW] || ram_we_o !== (!oor && we_i[g])) begin n_fail++; $display("FAIL rnd_bus[%0d]: got addr=%h we=%b want %h/%b", c, ram_addr_o, ram_we_o, addr_i[g*AW +: AW], !oor && we_i[g]); end
            end
            model_commit(g, oor);
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        exp_v = p_vld ? NP'(1 << p_port) : '0;
        n_cmp++; if (rvalid_o !== exp_v) begin n_fail++; $display("FAIL rnd_rvalid_last: got %b want %b", rvalid_o, exp_v); end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < RS; i++) m_mem[i] = seed_byte(i);
        model_reset();
        rst_i = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_byte_write();
        test_out_of_range();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
